// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared states and timing constants for the LED bank arbiter
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        GAP    = 2'd2,
        FROZEN = 2'd3
    } state_t;

    localparam int DEBOUNCE_MS = 20;

    function automatic int ms_cycles(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/led_ms_tick.sv
// rtl/led_ms_tick.sv - 1 ms prescaler with synchronous clear, emits a one-cycle tick
module led_ms_tick
    import led_arb_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int MS = ms_cycles(CLK_HZ);
    localparam int PW = (MS > 1) ? $clog2(MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(MS - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tick depends only on the register so the clear path cannot loop back into it.
    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin owner of one 4-LED bank; LED_ARB_DEBOUNCE_EN adds switch debounce
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int N_REQ   = 4,
    parameter int HOLD_MS = 500,
    parameter int GAP_MS  = 1000,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   pattern,
    input  logic                 switch,
    output logic [3:0]           led,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [CNT_W-1:0]     grant_count
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int LIM_MAX = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
    localparam int MS_W    = $clog2(LIM_MAX + 1);
    localparam logic [MS_W-1:0]  HOLD_LIM = MS_W'(HOLD_MS);
    localparam logic [MS_W-1:0]  GAP_LIM  = MS_W'(GAP_MS);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W+1)'(N_REQ);

    state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_winner, w_winner_next;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_next;
    logic [N_REQ-1:0]       r_grant, w_grant_next;
    logic [3:0]             r_led, w_led_next;
    logic [CNT_W-1:0]       r_count, w_count_next;
    logic [MS_W-1:0]        r_ms_cnt, w_ms_next, w_ms_lim;
    logic                   w_clr;
    logic                   w_tick;
    logic                   w_freeze;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W:0]         w_rr_inc;
    logic [3:0]             w_pats [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_pat
        assign w_pats[g] = pattern[4*g +: 4];
    end

    led_ms_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

`ifdef LED_ARB_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

    logic            r_sw_meta, r_sw_sync, r_freeze;
    logic [DB_W-1:0] r_db_cnt;

    // The freeze level only follows the synchronised switch after it has differed for DEBOUNCE_MS ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
            r_freeze  <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync == r_freeze) begin
                r_db_cnt <= '0;
            end else if (w_tick) begin
                if (r_db_cnt == DB_LAST) begin
                    r_freeze <= r_sw_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

    assign w_freeze = r_freeze;
`else
    assign w_freeze = switch;
`endif

    // Round-robin search: descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= N_WIDE) begin
                w_sum = w_sum - N_WIDE;
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_rr_inc = {1'b0, r_winner} + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_winner_next = r_winner;
        w_rr_next     = r_rr_ptr;
        w_grant_next  = r_grant;
        w_led_next    = r_led;
        w_count_next  = r_count;
        w_clr         = 1'b0;
        w_ms_lim      = (r_state == GAP) ? GAP_LIM : HOLD_LIM;
        w_ms_next     = (w_tick && (r_ms_cnt != w_ms_lim)) ? r_ms_cnt + 1'b1 : r_ms_cnt;

        if (w_freeze) begin
            w_state_next = FROZEN;
            w_grant_next = '0;
            w_led_next   = 4'd0;
            w_rr_next    = '0;
            // Clear only on entry so the prescaler keeps ticking while frozen.
            w_clr        = (r_state != FROZEN);
        end else begin
            case (r_state)
                IDLE: begin
                    w_led_next = 4'd0;
                    if (w_found) begin
                        w_state_next          = HOLD;
                        w_winner_next         = w_pick;
                        w_grant_next          = '0;
                        w_grant_next[w_pick]  = 1'b1;
                        w_led_next            = w_pats[w_pick];
                        w_clr                 = 1'b1;
                    end
                end
                HOLD: begin
                    if (!req[r_winner] ||
                        ((w_ms_next == HOLD_LIM) && |(req & ~r_grant))) begin
                        w_state_next = GAP;
                        w_grant_next = '0;
                        w_led_next   = 4'd0;
                        w_count_next = r_count + 1'b1;
                        w_rr_next    = (w_rr_inc >= N_WIDE) ? '0 : w_rr_inc[IDX_W-1:0];
                        w_clr        = 1'b1;
                    end else begin
                        w_led_next   = w_pats[r_winner];
                    end
                end
                GAP: begin
                    w_led_next = 4'd0;
                    if (w_ms_next == GAP_LIM) begin
                        w_state_next = IDLE;
                        w_clr        = 1'b1;
                    end
                end
                FROZEN: begin
                    w_state_next = IDLE;
                    w_clr        = 1'b1;
                end
                default: begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_led_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_led    <= 4'd0;
            r_count  <= '0;
            r_ms_cnt <= '0;
        end else begin
            r_winner <= w_winner_next;
            r_rr_ptr <= w_rr_next;
            r_grant  <= w_grant_next;
            r_led    <= w_led_next;
            r_count  <= w_count_next;
            if (w_clr) begin
                r_ms_cnt <= '0;
            end else if ((r_state == HOLD) || (r_state == GAP)) begin
                r_ms_cnt <= w_ms_next;
            end
        end
    end

    assign led         = r_led;
    assign grant       = r_grant;
    assign busy        = (r_state == HOLD) || (r_state == GAP);
    assign grant_count = r_count;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - scoreboard bench for led_bank_arbiter
module tb_led_bank_arbiter;

    localparam int CLK_HZ  = 10000;
    localparam int N_REQ   = 4;
    localparam int HOLD_MS = 5;
    localparam int GAP_MS  = 10;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [3:0]       req = 4'd0;
    logic [15:0]      pattern = 16'd0;
    logic             sw = 1'b0;
    logic [3:0]       led;
    logic [3:0]       grant;
    logic             busy;
    logic [CNT_W-1:0] grant_count;

    led_bank_arbiter #(
        .CLK_HZ  (CLK_HZ),
        .N_REQ   (N_REQ),
        .HOLD_MS (HOLD_MS),
        .GAP_MS  (GAP_MS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .pattern     (pattern),
        .switch      (sw),
        .led         (led),
        .grant       (grant),
        .busy        (busy),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               at;
        logic [3:0]       g;
        logic [3:0]       l;
        logic             b;
        logic [CNT_W-1:0] c;
    } ev_t;

    ev_t      q[$];
    ev_t      mon_e;
    int       checks = 0;
    int       failures = 0;
    bit       mon_en = 1'b0;
    logic [8:0] prev;
    logic [8:0] snap;

    task automatic push(input int at, input logic [3:0] g, input logic [3:0] l,
                        input logic b, input int c);
        ev_t e;
        e.at = at;
        e.g  = g;
        e.l  = l;
        e.b  = b;
        e.c  = CNT_W'(c % 8);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        if (t > cyc) tick(t - cyc);
    endtask

    task automatic do_reset();
        chk("sb_drain", q.size(), 0);
        q.delete();
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", {28'd0, grant}, 0);
        chk("rst_led", {28'd0, led}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_count", {29'd0, grant_count}, 0);
        req = 4'd0;
        sw  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        prev   = {grant, led, busy};
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            snap = {grant, led, busy};
            if (snap !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d grant=%b led=%b busy=%b count=%0d",
                             cyc, grant, led, busy, grant_count);
                end else begin
                    mon_e = q.pop_front();
                    if (cyc != mon_e.at || grant !== mon_e.g || led !== mon_e.l ||
                        busy !== mon_e.b || grant_count !== mon_e.c) begin
                        failures++;
                        $display("FAIL event got cyc=%0d grant=%b led=%b busy=%b count=%0d required cyc=%0d grant=%b led=%b busy=%b count=%0d",
                                 cyc, grant, led, busy, grant_count,
                                 mon_e.at, mon_e.g, mon_e.l, mon_e.b, mon_e.c);
                    end
                end
                prev = snap;
            end
        end
    end

    initial begin
        int n;
        int s;
        int f;

        // Single requester: grant, indefinite hold, pattern follow, early release.
        do_reset();
        n = cyc;
        pattern = 16'h000A;
        req = 4'b0001;
        push(n + 1, 4'b0001, 4'b1010, 1'b1, 0);
        tick(60);
        pattern = 16'h0005;
        push(cyc + 1, 4'b0001, 4'b0101, 1'b1, 0);
        tick(3);
        req = 4'b0000;
        n = cyc;
        push(n + 1, 4'b0000, 4'b0000, 1'b1, 1);
        push(n + 101, 4'b0000, 4'b0000, 1'b0, 1);
        tick(110);

        // Preemption after the minimum hold, then gap, then next owner.
        do_reset();
        n = cyc;
        pattern = 16'h030A;
        req = 4'b0001;
        push(n + 1, 4'b0001, 4'b1010, 1'b1, 0);
        tick(10);
        req = 4'b0101;
        push(n + 51, 4'b0000, 4'b0000, 1'b1, 1);
        push(n + 151, 4'b0000, 4'b0000, 1'b0, 1);
        push(n + 152, 4'b0100, 4'b0011, 1'b1, 1);
        goto(n + 155);
        req = 4'b0000;
        push(n + 156, 4'b0000, 4'b0000, 1'b1, 2);
        push(n + 256, 4'b0000, 4'b0000, 1'b0, 2);
        goto(n + 265);

        // Early release by requester 1; search resumes at index 2.
        do_reset();
        n = cyc;
        pattern = 16'h8421;
        req = 4'b0010;
        push(n + 1, 4'b0010, 4'b0010, 1'b1, 0);
        goto(n + 20);
        req = 4'b1001;
        push(n + 21, 4'b0000, 4'b0000, 1'b1, 1);
        push(n + 121, 4'b0000, 4'b0000, 1'b0, 1);
        push(n + 122, 4'b1000, 4'b1000, 1'b1, 1);
        goto(n + 130);
        req = 4'b0000;
        push(n + 131, 4'b0000, 4'b0000, 1'b1, 2);
        push(n + 231, 4'b0000, 4'b0000, 1'b0, 2);
        goto(n + 240);

        // All requesting: rotation, then freeze mid-hold of requester 2.
        do_reset();
        n = cyc;
        pattern = 16'h8421;
        req = 4'b1111;
        for (int k = 0; k <= 6; k++) begin
            s = n + 1 + 151 * k;
            push(s, 4'(1 << (k % 4)), 4'(1 << (k % 4)), 1'b1, k);
            if (k < 6) begin
                push(s + 50, 4'b0000, 4'b0000, 1'b1, k + 1);
                push(s + 150, 4'b0000, 4'b0000, 1'b0, k + 1);
            end
        end
        goto(n + 1 + 151 * 6 + 20);
        sw = 1'b1;
        push(cyc + 1, 4'b0000, 4'b0000, 1'b0, 6);
        tick(20);
        sw = 1'b0;
        f = cyc;
        push(f + 2, 4'b0001, 4'b0001, 1'b1, 6);
        tick(8);
        req = 4'b0000;
        sw  = 1'b1;
        push(cyc + 1, 4'b0000, 4'b0000, 1'b0, 6);
        tick(5);
        sw = 1'b0;
        tick(5);

        // Count wrap after 8 grants, then asynchronous reset mid-gap.
        do_reset();
        n = cyc;
        pattern = 16'h8421;
        req = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            s = n + 1 + 151 * k;
            push(s, 4'(1 << (k % 4)), 4'(1 << (k % 4)), 1'b1, k);
            push(s + 50, 4'b0000, 4'b0000, 1'b1, k + 1);
            if (k < 8) begin
                push(s + 150, 4'b0000, 4'b0000, 1'b0, k + 1);
            end
        end
        goto(n + 1 + 151 * 8 + 80);
        do_reset();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
